// File: rtl/aci_tape_writer_if.sv
// RAM read port between the ACI tape writer (master) and the CPU RAM (slave).
interface aci_tape_writer_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_din;

    modport master (output mem_addr, output mem_rd, input mem_din);
    modport slave  (input mem_addr, input mem_rd, output mem_din);
endinterface

// File: rtl/aci_tape_writer.sv
// Apple-1 ACI cassette writer: streams a RAM range as leader, sync and MSB-first bit cycles.
// Optional macro ACI_CHECKSUM_EN appends a running-XOR checksum byte after the data.
module aci_tape_writer #(
    parameter int HALF_ONE      = 500,
    parameter int HALF_ZERO     = 250,
    parameter int LEADER_CYCLES = 10000,
    parameter int SYNC_HI       = 200,
    parameter int SYNC_LO       = 250
) (
    input  logic                sys_clock,
    input  logic                reset,
    input  logic                clk_ena,
    input  logic                start,
    input  logic [15:0]         start_addr,
    input  logic [15:0]         end_addr,
    aci_tape_writer_if.master   mem,
    output logic                tape_out,
    output logic                busy,
    output logic                done
);

    localparam int MAX_A    = (HALF_ONE > HALF_ZERO) ? HALF_ONE : HALF_ZERO;
    localparam int MAX_B    = (SYNC_HI > SYNC_LO) ? SYNC_HI : SYNC_LO;
    localparam int MAX_HALF = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_HALF + 1);
    localparam int LW       = $clog2(LEADER_CYCLES + 1);

    localparam logic [CW-1:0] ONE_M1     = CW'(HALF_ONE - 1);
    localparam logic [CW-1:0] ZERO_M1    = CW'(HALF_ZERO - 1);
    localparam logic [CW-1:0] SYNC_HI_M1 = CW'(SYNC_HI - 1);
    localparam logic [CW-1:0] SYNC_LO_M1 = CW'(SYNC_LO - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [LW-1:0] LCYC_M1    = LW'(LEADER_CYCLES - 1);
    localparam logic [LW-1:0] LCYC_ONE   = LW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEADER = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_BITS   = 3'd5;
`ifdef ACI_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd6;
`endif
    localparam logic [2:0] S_FINISH = 3'd7;

    logic [2:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [LW-1:0] lcyc_r;
    logic          phase_hi_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic [15:0]   addr_r;
    logic [15:0]   end_r;
    logic [15:0]   mem_addr_r;
    logic          mem_rd_r;
    logic          tape_r;
    logic          busy_r;
    logic          done_r;
`ifdef ACI_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif

    // Ticks minus one for a half-cycle carrying the given bit value.
    function automatic logic [CW-1:0] half_m1(input logic b);
        return b ? ONE_M1 : ZERO_M1;
    endfunction

    assign mem.mem_addr = mem_addr_r;
    assign mem.mem_rd   = mem_rd_r;
    assign tape_out     = tape_r;
    assign busy         = busy_r;
    assign done         = done_r;

    // Transfer sequencer; every state change waits for a tick, only done self-clears each cycle.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            lcyc_r     <= '0;
            phase_hi_r <= 1'b0;
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            addr_r     <= 16'h0000;
            end_r      <= 16'h0000;
            mem_addr_r <= 16'h0000;
            mem_rd_r   <= 1'b0;
            tape_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef ACI_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            done_r <= 1'b0;
            if (clk_ena) begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            addr_r <= start_addr;
                            end_r  <= end_addr;
                            if (end_addr < start_addr) begin
                                done_r <= 1'b1;
                            end else begin
                                busy_r     <= 1'b1;
                                state_r    <= S_LEADER;
                                tape_r     <= 1'b1;
                                phase_hi_r <= 1'b1;
                                cnt_r      <= ONE_M1;
                                lcyc_r     <= LCYC_M1;
`ifdef ACI_CHECKSUM_EN
                                csum_r     <= 8'h00;
`endif
                            end
                        end
                    end
                    S_LEADER: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (phase_hi_r) begin
                            tape_r     <= 1'b0;
                            phase_hi_r <= 1'b0;
                            cnt_r      <= ONE_M1;
                        end else if (lcyc_r != '0) begin
                            lcyc_r     <= lcyc_r - LCYC_ONE;
                            tape_r     <= 1'b1;
                            phase_hi_r <= 1'b1;
                            cnt_r      <= ONE_M1;
                        end else begin
                            state_r    <= S_SYNC;
                            tape_r     <= 1'b1;
                            phase_hi_r <= 1'b1;
                            cnt_r      <= SYNC_HI_M1;
                        end
                    end
                    S_SYNC: begin
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (phase_hi_r) begin
                            tape_r     <= 1'b0;
                            phase_hi_r <= 1'b0;
                            cnt_r      <= SYNC_LO_M1;
                        end else begin
                            state_r    <= S_FETCH;
                            mem_addr_r <= addr_r;
                            mem_rd_r   <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        mem_rd_r <= 1'b0;
                        state_r  <= S_LATCH;
                    end
                    S_LATCH: begin
                        shift_r    <= mem.mem_din;
                        bit_r      <= 3'd7;
                        tape_r     <= 1'b1;
                        phase_hi_r <= 1'b1;
                        cnt_r      <= half_m1(mem.mem_din[7]);
                        state_r    <= S_BITS;
`ifdef ACI_CHECKSUM_EN
                        csum_r     <= csum_r ^ mem.mem_din;
`endif
                    end
`ifdef ACI_CHECKSUM_EN
                    S_BITS, S_CSUM: begin
`else
                    S_BITS: begin
`endif
                        if (cnt_r != '0) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (phase_hi_r) begin
                            tape_r     <= 1'b0;
                            phase_hi_r <= 1'b0;
                            cnt_r      <= half_m1(shift_r[7]);
                        end else if (bit_r != 3'd0) begin
                            bit_r      <= bit_r - 3'd1;
                            shift_r    <= {shift_r[6:0], 1'b0};
                            tape_r     <= 1'b1;
                            phase_hi_r <= 1'b1;
                            cnt_r      <= half_m1(shift_r[6]);
`ifdef ACI_CHECKSUM_EN
                        end else if (state_r == S_CSUM) begin
                            state_r <= S_FINISH;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            tape_r  <= 1'b0;
                        end else if (addr_r == end_r) begin
                            // Checksum byte follows the last data bit directly, without fetch gap.
                            state_r    <= S_CSUM;
                            shift_r    <= csum_r;
                            bit_r      <= 3'd7;
                            tape_r     <= 1'b1;
                            phase_hi_r <= 1'b1;
                            cnt_r      <= half_m1(csum_r[7]);
`else
                        end else if (addr_r == end_r) begin
                            state_r <= S_FINISH;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            tape_r  <= 1'b0;
`endif
                        end else begin
                            addr_r     <= addr_r + 16'd1;
                            mem_addr_r <= addr_r + 16'd1;
                            mem_rd_r   <= 1'b1;
                            state_r    <= S_FETCH;
                        end
                    end
                    S_FINISH: begin
                        state_r <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
